// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared constants for the data-memory arbiter.
// Holds the state encoding, port indices, sign_mask fields and a port helper.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int SM_SIGNED = 3;
    localparam int SM_WORD   = 2;
    localparam int SM_HALF   = 1;
    localparam int SM_BYTE   = 0;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// arb_pick2: combinational winner select between two requesters.
// Ports: req0/req1, last_gnt in; winner out. DATA_MEM_ARB_RR_EN selects round-robin.
module arb_pick2
    import data_mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner
);

`ifdef DATA_MEM_ARB_RR_EN
    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1)
            winner = other_port(last_gnt);
        else if (req1)
            winner = PORT_AUX;
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        winner = PORT_CPU;
        if (req1 && !req0)
            winner = PORT_AUX;
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-ported data memory between the CPU (port 0)
// and a secondary master (port 1); one strobe per access, ack once clk_stall drains.
// Ports: clk/reset; per port req/we/addr/wdata/sign_mask in, ack/rdata out;
// mem_addr/mem_write_data/mem_sign_mask/mem_memread/mem_memwrite out,
// mem_read_data/mem_clk_stall in; busy, gnt_id out.
// Define DATA_MEM_ARB_RR_EN for round-robin tie-break (default: port 0 fixed priority).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [3:0]        sign_mask0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [3:0]        sign_mask1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_sign_mask,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall,
    output logic              busy,
    output logic              gnt_id
);

    arb_state_t state;
    logic       seen_stall;
    logic       gnt_we;
    logic       winner;
    logic       last_gnt;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_mask;

`ifndef DATA_MEM_ARB_RR_EN
    assign last_gnt = 1'b1;
`endif

    arb_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

    assign sel_we    = (winner == PORT_AUX) ? we1        : we0;
    assign sel_addr  = (winner == PORT_AUX) ? addr1      : addr0;
    assign sel_wdata = (winner == PORT_AUX) ? wdata1     : wdata0;
    assign sel_mask  = (winner == PORT_AUX) ? sign_mask1 : sign_mask0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            seen_stall     <= 1'b0;
            gnt_we         <= 1'b0;
            gnt_id         <= PORT_CPU;
            busy           <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
            last_gnt       <= PORT_AUX;
`endif
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A stall seen here is a leftover access (e.g. after reset); let it drain.
                    if (!mem_clk_stall && (req0 || req1)) begin
                        gnt_id         <= winner;
                        gnt_we         <= sel_we;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_sign_mask  <= sel_mask;
                        mem_memread    <= !sel_we;
                        mem_memwrite   <= sel_we;
                        busy           <= 1'b1;
                        state          <= ISSUE;
`ifdef DATA_MEM_ARB_RR_EN
                        last_gnt       <= winner;
`endif
                    end
                end
                ISSUE: begin
                    seen_stall <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // Completion is the falling edge of the busy window, not its absence.
                    if (mem_clk_stall) begin
                        seen_stall <= 1'b1;
                    end else if (seen_stall) begin
                        if (gnt_id == PORT_AUX) begin
                            rdata1 <= gnt_we ? '0 : mem_read_data;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= gnt_we ? '0 : mem_read_data;
                            ack0   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter
// against a transaction-level model and a stalling memory fixture.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [3:0]  mask0 = 0, mask1 = 0;
    logic        ack0, ack1, busy, gnt_id;
    logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, mem_clk_stall;

    int n_chk = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;
    logic mem_init = 1'b1;
    logic rand_stall = 1'b0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .sign_mask0(mask0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .sign_mask1(mask1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_sign_mask(mem_sign_mask), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .busy(busy), .gnt_id(gnt_id)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 60)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory fixture: 64 bytes, stall window after each strobe
    logic [31:0] mem_w [0:15];
    int          mcnt;
    logic        f_we;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_mask;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h0101_0101) ^ 32'hC35A_0F00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (m[SM_BYTE]) r[int'(a) * 8 +: 8] = wd[7:0];
        else if (m[SM_HALF]) r[int'(a[1]) * 16 +: 16] = wd[15:0];
        else r = wd;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_w[i] <= init_word(i);
            mcnt <= 0;
            mem_read_data <= '0;
        end else if (mem_memread || mem_memwrite) begin
            mcnt    <= rand_stall ? int'($urandom_range(1, 3)) : 2;
            f_we    <= mem_memwrite;
            f_addr  <= mem_addr;
            f_wdata <= mem_write_data;
            f_mask  <= mem_sign_mask;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                if (f_we) mem_w[f_addr[5:2]] <= merge(mem_w[f_addr[5:2]], f_wdata, f_mask, f_addr[1:0]);
                else mem_read_data <= mem_w[f_addr[5:2]];
            end
        end
    end
    assign mem_clk_stall = (mcnt != 0);

    // ---------------- transaction-level model
    logic        m_inflight, m_latched, m_saw, m_port, m_we, m_gnt, m_last;
    int          m_age, m_ack_age;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] m_rdata [2];

    function automatic logic pick(input logic r0, input logic r1, input logic last);
`ifdef DATA_MEM_ARB_RR_EN
        if (r0 && r1) return !last;
`else
        if (r0 && r1) return 1'b0;
`endif
        return r1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_inflight = 0; m_latched = 0; m_saw = 0; m_port = 0; m_we = 0;
            m_gnt = 0; m_last = 1; m_age = 0; m_ack_age = 0;
            m_addr = 0; m_wdata = 0; m_mask = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
        end else if (!m_inflight) begin
            if (!mem_clk_stall && (req0 || req1)) begin
                m_port = pick(req0, req1, m_last);
                m_last = m_port;
                m_gnt = m_port;
                m_we    = m_port ? we1 : we0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                m_mask  = m_port ? mask1 : mask0;
                m_inflight = 1; m_latched = 0; m_saw = 0; m_age = 1;
            end
        end else begin
            if (m_latched && m_age == m_ack_age) begin
                m_inflight = 0;
            end else if (!m_latched && m_age >= 2) begin
                if (mem_clk_stall) m_saw = 1;
                else if (m_saw) begin
                    m_latched = 1;
                    m_ack_age = m_age + 1;
                    m_rdata[m_port] = m_we ? 32'h0 : mem_read_data;
                end
            end
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic e_ack;
            e_ack = m_inflight && m_latched && (m_age == m_ack_age);
            check("memread", mem_memread, m_inflight && m_age == 1 && !m_we);
            check("memwrite", mem_memwrite, m_inflight && m_age == 1 && m_we);
            check("ack0", ack0, e_ack && !m_port);
            check("ack1", ack1, e_ack && m_port);
            check("busy", busy, m_inflight);
            check("gnt_id", gnt_id, m_gnt);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_write_data, m_wdata);
            check("mem_mask", mem_sign_mask, m_mask);
            check("rdata0", rdata0, m_rdata[0]);
            check("rdata1", rdata1, m_rdata[1]);
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port, input int limit, output int cyc);
        cyc = 0;
        while (1) begin
            tick();
            cyc++;
            if ((port == 0 ? ack0 : ack1) === 1'b1) break;
            if (cyc >= limit) begin
                n_chk++; n_fail++;
                $display("FAIL ack%0d timeout: none after %0d cycles, required within %0d", port, cyc, limit);
                break;
            end
        end
    endtask

    function automatic logic [3:0] rand_mask();
        logic [3:0] m;
        m = 4'b0;
        m[SM_SIGNED] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0: m[SM_BYTE] = 1'b1;
            1: m[SM_HALF] = 1'b1;
            default: m[SM_WORD] = 1'b1;
        endcase
        return m;
    endfunction

    initial begin
        int cyc, a0, a1, nw;
        logic [3:0] mword, mbyte;
        mword = 4'b0; mword[SM_WORD] = 1'b1;
        mbyte = 4'b0; mbyte[SM_BYTE] = 1'b1;

        repeat (3) tick();
        check("rst busy", busy, 0);
        check("rst strobes", {mem_memread, mem_memwrite, ack0, ack1}, 0);
        check("rst gnt_id", gnt_id, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst rdata", {rdata0, rdata1}, 0);
        reset = 0; mem_init = 0; cmp_en = 1;
        tick();

        // tie right after reset: port 0 first, port 1 issues cycle 7, acks cycle 11
        req0 = 1; we0 = 0; addr0 = 32'h10; mask0 = mword;
        req1 = 1; we1 = 0; addr1 = 32'h24; mask1 = mword;
        wait_ack(0, 20, cyc); check("tie ack0 cycle", cyc, 5);
        req0 = 0;
        tick(); tick();
        check("tie p1 issue c7", {gnt_id, mem_memread}, 2'b11);
        wait_ack(1, 20, cyc); check("tie ack1 cycle", cyc, 4);
        req1 = 0;
        tick();
        req0 = 1; req1 = 1;
        tick();
        check("retie gnt port0", {gnt_id, mem_memread}, 2'b01);
        wait_ack(0, 20, cyc); req0 = 0;
        wait_ack(1, 20, cyc); check("retie ack1 cycle", cyc, 6);
        req1 = 0;
        tick();

        // both held continuously for 30 cycles
        req0 = 1; req1 = 1; a0 = 0; a1 = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            a0 += int'(ack0); a1 += int'(ack1);
        end
`ifdef DATA_MEM_ARB_RR_EN
        check("held ack0 count", a0, 3);
        check("held ack1 count", a1, 2);
`else
        check("held ack0 count", a0, 5);
        check("held ack1 starved", a1, 0);
`endif
        req0 = 0;
        wait_ack(1, 20, cyc); check("held p1 after release", cyc, 5);
        req1 = 0;
        tick();

        // port 0 word load of 0xDEADBEEF
        req0 = 1; we0 = 0; addr0 = 32'h10; mask0 = mword;
        tick(); check("ld memread c1", mem_memread, 1);
        tick(); check("ld memread c2", mem_memread, 0);
        tick(); tick(); check("ld no ack c4", ack0, 0);
        tick();
        check("ld ack0 c5", {ack0, ack1}, 2'b10);
        check("ld rdata0", rdata0, 32'hDEADBEEF);
        req0 = 0;
        tick();

        // port 1 byte store, then word load sees it in lane 1
        req1 = 1; we1 = 1; addr1 = 32'h21; wdata1 = 32'hA5; mask1 = mbyte;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nw += int'(mem_memwrite);
        end
        check("st one memwrite", nw, 1);
        check("st ack1 c5", ack1, 1);
        check("st rdata1", rdata1, 0);
        req1 = 0;
        tick();
        req0 = 1; we0 = 0; addr0 = 32'h20; mask0 = mword;
        wait_ack(0, 20, cyc);
        check("st readback lat", cyc, 5);
        check("st readback byte", rdata0[15:8], 8'hA5);
        req0 = 0;
        tick();

        // req0 held past ack is a second load, issued cycle 7
        req0 = 1; addr0 = 32'h10;
        wait_ack(0, 20, cyc);
        tick(); tick();
        check("rehold issue c7", mem_memread, 1);
        wait_ack(0, 20, cyc); check("rehold ack cycle", cyc, 4);
        req0 = 0;
        tick();

        // reset in cycle 2 of a load, released in cycle 3
        req0 = 1; we0 = 0; addr0 = 32'h10; mask0 = mword;
        tick(); tick();
        reset = 1;
        #1;
        check("mid-rst busy", busy, 0);
        check("mid-rst mem_addr", mem_addr, 0);
        check("mid-rst rdata0", rdata0, 0);
        tick();
        check("mid-rst mem stall c3", mem_clk_stall, 1);
        reset = 0;
        tick(); check("no issue in drain c4", {busy, mem_memread}, 0);
        tick(); check("reissue c5", mem_memread, 1);
        wait_ack(0, 20, cyc);
        check("reissue ack", cyc, 4);
        check("reissue rdata0", rdata0, 32'hDEADBEEF);
        req0 = 0;
        tick();

        // random traffic with variable stall window
        rand_stall = 1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (req0 && ack0) req0 = 0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                we0 = 1'($urandom_range(0, 1));
                addr0 = {26'b0, 6'($urandom_range(0, 63))};
                wdata0 = $urandom; mask0 = rand_mask(); req0 = 1;
            end
            if (req1 && ack1) req1 = 0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                we1 = 1'($urandom_range(0, 1));
                addr1 = {26'b0, 6'($urandom_range(0, 63))};
                wdata1 = $urandom; mask1 = rand_mask(); req1 = 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
